can_destuff_ext: RTL

Parametrised bit destuffer for the CAN/CAN-FD receive path. It sits between the bit sampler and can_rx. It consumes one sampled bit per bit-time strobe and forwards only data bits. It silently drops dynamic stuff bits (after RUN_LEN identical bits) and CAN-FD fixed stuff bits (every FIXED_LEN bits), flags stuff errors, and keeps the modulo-8 dynamic stuff count needed for the FD stuff-count field.

---
 rtl/can_pkg.sv | 16 +
 rtl/can_run_tracker.sv | 51 +++++
 rtl/can_destuff_ext.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN receive/transmit definitions: bus levels, destuffer states and widths.
package can_pkg;

  typedef enum logic [2:0] {
    NORMAL,
    EXPECT_STUFF,
    FIXED,
    FIXED_EXPECT,
    ERROR
  } state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;
  localparam int   STUFF_CNT_W   = 3;

endpackage

// File: rtl/can_run_tracker.sv
// Last-bit register plus saturating identical-bit run counter; shared with the TX stuffer.
module can_run_tracker
  import can_pkg::*;
#(
  parameter int RUN_LEN = 5,
  parameter int CW      = $clog2(RUN_LEN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          upd_i,
  input  logic          zero_i,
  input  logic          bit_i,
  output logic [CW-1:0] run_o,
  output logic          same_o,
  output logic          run_hit_o
);

  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

  logic          last_q, last_d, base_last;
  logic [CW-1:0] run_q, run_d, base_run, cnt_next;

  // A clear in the same cycle as an update means the bit is judged against the cleared state.
  always_comb begin
    base_last = clr_i ? CAN_RECESSIVE : last_q;
    base_run  = clr_i ? '0 : run_q;
    same_o    = (bit_i == base_last);
    if (!same_o)                  cnt_next = CW'(1);
    else if (base_run == RUN_MAX) cnt_next = base_run;
    else                          cnt_next = base_run + CW'(1);
    run_hit_o = (cnt_next == RUN_MAX);
    last_d    = upd_i ? bit_i : base_last;
    if (zero_i)     run_d = '0;
    else if (upd_i) run_d = cnt_next;
    else            run_d = base_run;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= CAN_RECESSIVE;
      run_q  <= '0;
    end else begin
      last_q <= last_d;
      run_q  <= run_d;
    end
  end

  assign run_o = run_q;

endmodule

// File: rtl/can_destuff_ext.sv
// CAN/CAN-FD receive bit destuffer: drops dynamic and fixed stuff bits, flags stuff errors.
//   state        | meaning
//   NORMAL       | dynamic run counting, bits forwarded
//   EXPECT_STUFF | run hit RUN_LEN, next bit must be a complementary stuff bit
//   FIXED        | FD fixed-stuff region, counting data bits
//   FIXED_EXPECT | next bit must be a complementary fixed stuff bit
//   ERROR        | stuff error seen, ignoring bits until clear
module can_destuff_ext
  import can_pkg::*;
#(
  parameter int RUN_LEN   = 5,
  parameter int FIXED_LEN = 4,
  parameter int CW        = $clog2(RUN_LEN + 1)
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Bit_Valid,
  input  logic                   i_Bit,
  input  logic                   i_Clear,
  input  logic                   i_Enable,
  input  logic                   i_Fixed_Mode,
  output logic                   o_Bit_Valid,
  output logic                   o_Bit,
  output logic                   o_Stuff_Drop,
  output logic                   o_Stuff_Err,
  output logic [CW-1:0]          o_Run_Count,
  output logic [STUFF_CNT_W-1:0] o_Stuff_Count
);

  localparam int            FW      = $clog2(FIXED_LEN + 1);
  localparam logic [FW-1:0] FIX_MAX = FW'(FIXED_LEN);

  state_e                   state_q, state_d, base_state, eff_state;
  logic [FW-1:0]            fcnt_q, fcnt_d, base_fcnt;
  logic [STUFF_CNT_W-1:0]   scnt_q, scnt_d, base_scnt;
  logic                     err_q, err_d;
  logic                     bv_q, bv_d, bit_q, bit_d, drop_q, drop_d;
  logic                     trk_upd, trk_zero, trk_same, trk_hit;

  can_run_tracker #(.RUN_LEN(RUN_LEN), .CW(CW)) u_run (
    .clk_i     (i_Clock),
    .rst_ni    (i_Rst_n),
    .clr_i     (i_Clear),
    .upd_i     (trk_upd),
    .zero_i    (trk_zero),
    .bit_i     (i_Bit),
    .run_o     (o_Run_Count),
    .same_o    (trk_same),
    .run_hit_o (trk_hit)
  );

  always_comb begin
    base_state = i_Clear ? NORMAL : state_q;
    base_fcnt  = i_Clear ? '0 : fcnt_q;
    base_scnt  = i_Clear ? '0 : scnt_q;
    state_d    = base_state;
    eff_state  = base_state;
    fcnt_d     = base_fcnt;
    scnt_d     = base_scnt;
    err_d      = i_Clear ? 1'b0 : err_q;
    bit_d      = i_Clear ? CAN_DOMINANT : bit_q;
    bv_d       = 1'b0;
    drop_d     = 1'b0;
    trk_upd    = 1'b0;
    trk_zero   = 1'b0;
    if (i_Bit_Valid && base_state != ERROR) begin
      if (!i_Enable) begin
        bv_d     = 1'b1;
        bit_d    = i_Bit;
        trk_upd  = 1'b1;
        trk_zero = 1'b1;
        fcnt_d   = '0;
        state_d  = NORMAL;
      end else begin
        // Region changes take effect on the bit that first shows the new mode.
        if (i_Fixed_Mode && (base_state == NORMAL || base_state == EXPECT_STUFF)) begin
          eff_state = FIXED_EXPECT;
          trk_zero  = 1'b1;
        end else if (!i_Fixed_Mode && (base_state == FIXED || base_state == FIXED_EXPECT)) begin
          eff_state = NORMAL;
          fcnt_d    = '0;
        end
        case (eff_state)
          NORMAL: begin
            bv_d    = 1'b1;
            bit_d   = i_Bit;
            trk_upd = 1'b1;
            state_d = trk_hit ? EXPECT_STUFF : NORMAL;
          end
          EXPECT_STUFF: begin
            if (!trk_same) begin
              drop_d  = 1'b1;
              trk_upd = 1'b1;
              scnt_d  = base_scnt + STUFF_CNT_W'(1);
              state_d = NORMAL;
            end else begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
          end
          FIXED_EXPECT: begin
            if (!trk_same) begin
              drop_d   = 1'b1;
              trk_upd  = 1'b1;
              trk_zero = 1'b1;
              fcnt_d   = '0;
              state_d  = FIXED;
            end else begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
          end
          FIXED: begin
            bv_d     = 1'b1;
            bit_d    = i_Bit;
            trk_upd  = 1'b1;
            trk_zero = 1'b1;
            fcnt_d   = base_fcnt + FW'(1);
            state_d  = (fcnt_d == FIX_MAX) ? FIXED_EXPECT : FIXED;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= NORMAL;
      fcnt_q  <= '0;
      scnt_q  <= '0;
      err_q   <= 1'b0;
      bv_q    <= 1'b0;
      bit_q   <= CAN_DOMINANT;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
      bv_q    <= bv_d;
      bit_q   <= bit_d;
      drop_q  <= drop_d;
    end
  end

  assign o_Bit_Valid   = bv_q;
  assign o_Bit         = bit_q;
  assign o_Stuff_Drop  = drop_q;
  assign o_Stuff_Err   = err_q;
  assign o_Stuff_Count = scnt_q;

endmodule
